// File: rtl/fpu_seq_ctrl.sv
// Launch/retire sequencer for the multi-cycle FPU beside the ID stage.
// Tracks one in-flight op, raises ID stalls on structural and RAW/WAW hazards, and arbitrates writeback.
module fpu_seq_ctrl #(
  parameter int unsigned LAT_ADD = 3,
  parameter int unsigned LAT_MUL = 4,
  parameter int unsigned LAT_DIV = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid_id,
  input  logic       flush_id,
  input  logic [4:0] funct5_id,
  input  logic [4:0] rd_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic       regwrite_id,
  input  logic       wb_ready,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic       stall_id,
  output logic       fpu_wb_en,
  output logic [4:0] fpu_wb_rd,
  output logic       busy,
  output logic       illegal_op
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_en_q, wb_en_d;
  logic             illegal_q, illegal_d;

  logic             legal;
  logic             issue_ok;
  logic             accept;
  logic             busy_w;
  logic             raw_hit;
  logic             waw_hit;
  logic [CNT_W-1:0] lat_m1;

  // Only funct5 00000..00011 are implemented; the low two bits double as fpu_op.
  assign legal    = (funct5_id[4:2] == 3'b000);
  assign issue_ok = issue_valid_id & ~flush_id;
  assign busy_w   = (state_q != StIdle);
  assign accept   = issue_ok & legal & ~busy_w;

  always_comb begin
    lat_m1 = CNT_W'(LAT_ADD - 1);
    case (funct5_id[1:0])
      2'b10:   lat_m1 = CNT_W'(LAT_MUL - 1);
      2'b11:   lat_m1 = CNT_W'(LAT_DIV - 1);
      default: lat_m1 = CNT_W'(LAT_ADD - 1);
    endcase
  end

  // rd=0 results are discarded downstream, so they never create a hazard.
  assign raw_hit = (rs1_used_id & (rs1_id == rd_q)) | (rs2_used_id & (rs2_id == rd_q));
  assign waw_hit = regwrite_id & (rd_id == rd_q);

  assign stall_id = (issue_ok & busy_w) | (busy_w & (rd_q != 5'd0) & (raw_hit | waw_hit));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    wb_en_d   = wb_en_q;
    illegal_d = issue_ok & ~legal & ~busy_w;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StExec;
          cnt_d   = lat_m1;
          op_d    = funct5_id[1:0];
          rd_d    = rd_id;
        end
      end
      StExec: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = StWb;
          wb_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StWb: begin
        if (wb_ready) begin
          state_d = StIdle;
          wb_en_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        wb_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= 2'b00;
      rd_q      <= 5'd0;
      wb_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_en_q   <= wb_en_d;
      illegal_q <= illegal_d;
    end
  end

  assign fpu_start  = accept;
  assign fpu_op     = op_q;
  assign fpu_wb_en  = wb_en_q;
  assign fpu_wb_rd  = rd_q;
  assign busy       = busy_w;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Directed bench for fpu_seq_ctrl: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_fpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid_id, flush_id;
  logic [4:0] funct5_id, rd_id, rs1_id, rs2_id;
  logic       rs1_used_id, rs2_used_id, regwrite_id, wb_ready;
  logic       fpu_start, stall_id, fpu_wb_en, busy, illegal_op;
  logic [1:0] fpu_op;
  logic [4:0] fpu_wb_rd;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fpu_seq_ctrl #(
    .LAT_ADD(3),
    .LAT_MUL(4),
    .LAT_DIV(10),
    .CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_id(issue_valid_id),
    .flush_id      (flush_id),
    .funct5_id     (funct5_id),
    .rd_id         (rd_id),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rs1_used_id   (rs1_used_id),
    .rs2_used_id   (rs2_used_id),
    .regwrite_id   (regwrite_id),
    .wb_ready      (wb_ready),
    .fpu_start     (fpu_start),
    .fpu_op        (fpu_op),
    .stall_id      (stall_id),
    .fpu_wb_en     (fpu_wb_en),
    .fpu_wb_rd     (fpu_wb_rd),
    .busy          (busy),
    .illegal_op    (illegal_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && busy; i++) nxt();
    mid();
    chk(tag, busy, 1'b0);
    nxt();
  endtask

  initial begin
    rst = 1'b1; issue_valid_id = 1'b0; flush_id = 1'b0; funct5_id = 5'd0;
    rd_id = 5'd0; rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0;
    rs2_used_id = 1'b0; regwrite_id = 1'b0; wb_ready = 1'b0;
    nxt(); nxt();
    rst = 1'b0;
    mid();
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_en", fpu_wb_en, 1'b0);
    chk("rst_wb_rd", fpu_wb_rd, 5'd0);
    chk("rst_op", fpu_op, 2'd0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_stall", stall_id, 1'b0);
    nxt();

    // Add rd=5, latency 3, immediate grant
    issue_valid_id = 1'b1; funct5_id = 5'b00000; rd_id = 5'd5; wb_ready = 1'b1;
    mid();
    chk("add_start", fpu_start, 1'b1);
    chk("add_stall_T", stall_id, 1'b0);
    chk("add_busy_T", busy, 1'b0);
    nxt();
    issue_valid_id = 1'b0;
    mid();
    chk("add_busy_T1", busy, 1'b1);
    chk("add_wb_T1", fpu_wb_en, 1'b0);
    chk("add_op", fpu_op, 2'd0);
    chk("add_start_T1", fpu_start, 1'b0);
    nxt();
    mid();
    chk("add_wb_T2", fpu_wb_en, 1'b0);
    nxt();
    mid();
    chk("add_wb_T3", fpu_wb_en, 1'b1);
    chk("add_rd_T3", fpu_wb_rd, 5'd5);
    chk("add_busy_T3", busy, 1'b1);
    nxt();
    mid();
    chk("add_wb_T4", fpu_wb_en, 1'b0);
    chk("add_busy_T4", busy, 1'b0);
    nxt();

    // Div rd=9, then add rd=4 waiting in ID
    issue_valid_id = 1'b1; funct5_id = 5'b00011; rd_id = 5'd9;
    mid();
    chk("div_start", fpu_start, 1'b1);
    nxt();
    funct5_id = 5'b00000; rd_id = 5'd4;
    for (int i = 1; i <= 10; i++) begin
      mid();
      chk("div_struct_stall", stall_id, 1'b1);
      chk("div_no_start", fpu_start, 1'b0);
      if (i == 1) chk("div_op", fpu_op, 2'd3);
      if (i == 9) chk("div_wb_T9", fpu_wb_en, 1'b0);
      if (i == 10) begin
        chk("div_wb_T10", fpu_wb_en, 1'b1);
        chk("div_rd_T10", fpu_wb_rd, 5'd9);
      end
      nxt();
    end
    mid();
    chk("b2b_stall_T11", stall_id, 1'b0);
    chk("b2b_start_T11", fpu_start, 1'b1);
    nxt();
    issue_valid_id = 1'b0;
    mid();
    chk("b2b_op", fpu_op, 2'd0);
    chk("b2b_rd", fpu_wb_rd, 5'd4);
    drain("b2b_drain");

    // RAW/WAW against mul rd=7, grant delayed
    wb_ready = 1'b0;
    issue_valid_id = 1'b1; funct5_id = 5'b00010; rd_id = 5'd7;
    mid();
    chk("mul_start", fpu_start, 1'b1);
    nxt();
    issue_valid_id = 1'b0; rd_id = 5'd0; rs2_id = 5'd7; rs2_used_id = 1'b1;
    mid();
    chk("raw_stall_T1", stall_id, 1'b1);
    nxt();
    rs2_used_id = 1'b0; regwrite_id = 1'b1; rd_id = 5'd7;
    mid();
    chk("waw_stall_T2", stall_id, 1'b1);
    nxt();
    regwrite_id = 1'b0; rd_id = 5'd0; rs2_used_id = 1'b1;
    mid();
    chk("raw_stall_T3", stall_id, 1'b1);
    nxt();
    mid();
    chk("mul_wb_T4", fpu_wb_en, 1'b1);
    chk("raw_stall_T4", stall_id, 1'b1);
    nxt();
    wb_ready = 1'b1;
    mid();
    chk("raw_stall_grant", stall_id, 1'b1);
    nxt();
    wb_ready = 1'b0;
    mid();
    chk("raw_release", stall_id, 1'b0);
    chk("raw_busy_after", busy, 1'b0);
    nxt();

    // rd=0 op: no hazards
    rs2_used_id = 1'b0;
    issue_valid_id = 1'b1; funct5_id = 5'b00010; rd_id = 5'd0;
    mid();
    chk("rd0_start", fpu_start, 1'b1);
    nxt();
    issue_valid_id = 1'b0; rs1_id = 5'd0; rs1_used_id = 1'b1; regwrite_id = 1'b1;
    mid();
    chk("rd0_no_stall", stall_id, 1'b0);
    chk("rd0_busy", busy, 1'b1);
    nxt();
    rs1_used_id = 1'b0; regwrite_id = 1'b0; wb_ready = 1'b1;
    drain("rd0_drain");

    // Write-port contention: add rd=3, no grant for 4 cycles
    wb_ready = 1'b0;
    issue_valid_id = 1'b1; funct5_id = 5'b00000; rd_id = 5'd3;
    mid();
    chk("wp_start", fpu_start, 1'b1);
    nxt();
    issue_valid_id = 1'b0;
    nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("wp_hold_en", fpu_wb_en, 1'b1);
      chk("wp_hold_rd", fpu_wb_rd, 5'd3);
      chk("wp_hold_busy", busy, 1'b1);
      nxt();
    end
    wb_ready = 1'b1;
    mid();
    chk("wp_grant_en", fpu_wb_en, 1'b1);
    nxt();
    wb_ready = 1'b0;
    mid();
    chk("wp_after_en", fpu_wb_en, 1'b0);
    chk("wp_after_busy", busy, 1'b0);
    nxt();

    // Illegal funct5
    issue_valid_id = 1'b1; funct5_id = 5'b10101; rd_id = 5'd8;
    mid();
    chk("ill_start", fpu_start, 1'b0);
    chk("ill_stall", stall_id, 1'b0);
    nxt();
    issue_valid_id = 1'b0;
    mid();
    chk("ill_pulse", illegal_op, 1'b1);
    chk("ill_busy", busy, 1'b0);
    nxt();
    mid();
    chk("ill_pulse_end", illegal_op, 1'b0);
    nxt();

    // Flush while idle, then flush while busy
    issue_valid_id = 1'b1; flush_id = 1'b1; funct5_id = 5'b00000; rd_id = 5'd6;
    mid();
    chk("flush_start", fpu_start, 1'b0);
    chk("flush_stall", stall_id, 1'b0);
    nxt();
    issue_valid_id = 1'b0; flush_id = 1'b0;
    mid();
    chk("flush_busy", busy, 1'b0);
    nxt();
    issue_valid_id = 1'b1; wb_ready = 1'b1;
    mid();
    chk("fb_start", fpu_start, 1'b1);
    nxt();
    flush_id = 1'b1;
    mid();
    chk("fb_flush_no_stall", stall_id, 1'b0);
    flush_id = 1'b0;
    #1;
    chk("fb_struct_stall", stall_id, 1'b1);
    issue_valid_id = 1'b0;
    drain("fb_drain");

    // Reset at T+2 of a div abandons it
    issue_valid_id = 1'b1; funct5_id = 5'b00011; rd_id = 5'd11;
    mid();
    chk("rdiv_start", fpu_start, 1'b1);
    nxt();
    issue_valid_id = 1'b0;
    nxt();
    rst = 1'b1;
    mid();
    chk("rdiv_busy_T2", busy, 1'b1);
    nxt();
    rst = 1'b0;
    mid();
    chk("rdiv_busy", busy, 1'b0);
    chk("rdiv_wb_en", fpu_wb_en, 1'b0);
    chk("rdiv_wb_rd", fpu_wb_rd, 5'd0);
    chk("rdiv_op", fpu_op, 2'd0);
    nxt();
    for (int i = 0; i < 12; i++) begin
      mid();
      chk("rdiv_no_wb", fpu_wb_en, 1'b0);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Sequencer for the multi-cycle FPU in the pipelined core.
- Sits beside the ID stage. Accepts FPU ops (opcode 1010011, alu_op_id = 2'b11) and launches them on the FPU with a per-class latency.
- Holds the pipeline on structural and RAW/WAW hazards against the in-flight destination register.
- Requests the shared register-file write port and waits for a grant before retiring the result.

Parameters:
- LAT_ADD, 3, cycles from fpu_start to result valid for add/sub (min 2)
- LAT_MUL, 4, same, for mul (min 2)
- LAT_DIV, 10, same, for div (min 2)
- CNT_W, 4, latency counter width; must hold max(LAT_*)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- issue_valid_id  in  1  FPU instruction valid in ID (alu_op_id==2'b11, not bubbled)
- flush_id  in  1  ID instruction is being squashed this cycle
- funct5_id  in  5  FPU operation select
- rd_id  in  5  destination register of the ID instruction
- rs1_id  in  5  source 1 of the ID instruction (any type)
- rs2_id  in  5  source 2 of the ID instruction (any type)
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- regwrite_id  in  1  ID instruction writes rd (regwrite_id from control decode)
- wb_ready  in  1  write-port grant from the writeback arbiter
- fpu_start  out  1  one-cycle launch pulse to the FPU (combinational)
- fpu_op  out  2  00 add, 01 sub, 10 mul, 11 div; held for the whole operation
- stall_id  out  1  freeze IF/ID, inject a bubble into EX (combinational)
- fpu_wb_en  out  1  result valid, write-port request (registered)
- fpu_wb_rd  out  5  destination of the result (registered)
- busy  out  1  operation in flight, state != IDLE (registered)
- illegal_op  out  1  one-cycle pulse on an unsupported funct5 (registered)

Behaviour:
- States: IDLE, EXEC, WB.
- Reset: state=IDLE, cnt=0, fpu_op=0, fpu_wb_rd=0, fpu_wb_en=0, busy=0, illegal_op=0. Reset in EXEC or WB abandons the operation; no writeback occurs.
- funct5 decode:
  - 00000 → add, LAT_ADD
  - 00001 → sub, LAT_ADD
  - 00010 → mul, LAT_MUL
  - 00011 → div, LAT_DIV
  - other → illegal_op pulses the next cycle; no launch, no stall, state unchanged.
- Acceptance in IDLE at cycle T: issue_valid_id & !flush_id & legal funct5.
  - fpu_start=1 at T.
  - Latch fpu_op and rd_id into fpu_wb_rd; cnt<=LAT-1; state→EXEC.
- EXEC: if cnt==1 → WB, else cnt<=cnt-1. fpu_wb_en rises at cycle T+LAT.
- WB: fpu_wb_en=1 is held until wb_ready.
  - On the wb_ready cycle the write occurs; fpu_wb_en<=0; state→IDLE.
  - A new op can be accepted at the earliest one cycle after the grant.
- busy=1 in EXEC and WB.
- stall_id=1 iff any of the following holds:
  - (a) issue_valid_id & !flush_id & state!=IDLE (structural)
  - (b) busy & fpu_wb_rd!=0 & ((rs1_used_id & rs1_id==fpu_wb_rd) | (rs2_used_id & rs2_id==fpu_wb_rd)) (RAW)
  - (c) busy & fpu_wb_rd!=0 & regwrite_id & rd_id==fpu_wb_rd (WAW)
- Hazard terms compare against the latched rd only. In the wb_ready cycle the stall still holds; it releases the following cycle.
- rd=0: an op is still executed and occupies the unit, but creates no RAW/WAW hazard. fpu_wb_en still asserts and the arbiter discards the write.
- flush_id has priority over issue: no launch, no structural stall. It does not abort an op already in flight.
- fpu_start is never asserted while busy=1.

Test Plan:
- Add issue: funct5=00000, rd=5 at T with wb_ready=1 → fpu_start at T; fpu_wb_en=1, fpu_wb_rd=5 at T+3 only; busy T+1..T+3.
- Div then back-to-back FPU op: div at T, add presented at T+1 → stall_id=1 T+1..T+10; add accepted at T+11 (fpu_start), wb_ready held 1.
- RAW: mul rd=7 in flight, ID add-int with rs2_id=7, rs2_used_id=1 → stall_id=1 until the cycle after the wb_ready grant. Same with rd=0 and rs1_id=0 → no stall.
- Write-port contention: add rd=3, wb_ready=0 for 4 cycles after T+3 → fpu_wb_en/fpu_wb_rd=3 held stable; state stays WB; IDLE the cycle after wb_ready=1.
- Illegal funct5=10101 → illegal_op pulses 1 cycle; fpu_start=0, busy=0, stall_id=0. Flush: issue_valid_id=1 with flush_id=1 → no launch.
- Reset mid-op: rst=1 at T+2 of a div → next cycle busy=0, fpu_wb_en=0, state IDLE; no later fpu_wb_en.
